// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the shared datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int ALUOP_W = 3,
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               mem_ready;
  logic               pcwrite;
  logic               pcwrite_cond;
  logic               bne;
  logic               iord;
  logic               memread;
  logic               memwrite;
  logic               irwrite;
  logic               memtoreg;
  logic [1:0]         regdst;
  logic               regwrite;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [ALUOP_W-1:0] aluop;
  logic [1:0]         pcsource;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode,
    input  funct,
    input  mem_ready,
    output pcwrite,
    output pcwrite_cond,
    output bne,
    output iord,
    output memread,
    output memwrite,
    output irwrite,
    output memtoreg,
    output regdst,
    output regwrite,
    output alusrca,
    output alusrcb,
    output aluop,
    output pcsource,
    output illegal_op,
    output state
  );

  modport slave (
    output opcode,
    output funct,
    output mem_ready,
    input  pcwrite,
    input  pcwrite_cond,
    input  bne,
    input  iord,
    input  memread,
    input  memwrite,
    input  irwrite,
    input  memtoreg,
    input  regdst,
    input  regwrite,
    input  alusrca,
    input  alusrcb,
    input  aluop,
    input  pcsource,
    input  illegal_op,
    input  state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the shared-ALU / unified-memory MIPS datapath.
// One datapath step per state; outputs registered from the next state.
module multicycle_ctrl #(
  parameter int ALUOP_W = 3,
  parameter int STATE_W = 4
) (
  input  logic              clock,
  input  logic              Reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTYPE  = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    JAL    = 4'd10,
    JR     = 4'd11,
    ADDI   = 4'd12,
    IWB    = 4'd13
  } state_t;

  typedef struct packed {
    logic               pcwrite;
    logic               pcwrite_cond;
    logic               bne;
    logic               iord;
    logic               memread;
    logic               memwrite;
    logic               fetch;
    logic               memtoreg;
    logic [1:0]         regdst;
    logic               regwrite;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         pcsource;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);

  state_t state_q;
  state_t nstate;
  state_t tgt;
  logic   run_q;
  logic   illegal_q;
  logic   bad_op;
  ctl_t   ctl_q;
  ctl_t   ctl_d;

  logic is_r;
  logic is_mem;
  logic is_br;
  logic is_j;
  logic is_jal;
  logic is_addi;

  assign is_r    = bus.opcode == OP_R;
  assign is_mem  = bus.opcode == OP_LW
                || bus.opcode == OP_SW;
  assign is_br   = bus.opcode == OP_BEQ
                || bus.opcode == OP_BNE;
  assign is_j    = bus.opcode == OP_J;
  assign is_jal  = bus.opcode == OP_JAL;
  assign is_addi = bus.opcode == OP_ADDI;

  always_comb begin
    nstate = FETCH;
    bad_op = 1'b0;
    case (state_q)
      FETCH:
        nstate = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          is_r:
            nstate = (bus.funct == FN_JR) ? JR : RTYPE;
          is_mem:  nstate = MEMADR;
          is_br:   nstate = BRANCH;
          is_j:    nstate = JUMP;
          is_jal:  nstate = JAL;
          is_addi: nstate = ADDI;
          default: begin
            nstate = FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      MEMADR:
        nstate = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:
        nstate = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:
        nstate = bus.mem_ready ? FETCH : MEMWR;
      RTYPE:   nstate = RWB;
      ADDI:    nstate = IWB;
      default: nstate = FETCH;
    endcase
  end

  // First edge after reset only arms the strobes; FETCH is held one cycle.
  assign tgt = run_q ? nstate : FETCH;

  always_comb begin
    ctl_d = '0;
    case (tgt)
      FETCH: begin
        ctl_d.memread = 1'b1;
        ctl_d.fetch   = 1'b1;
        ctl_d.alusrcb = 2'd1;
        ctl_d.aluop   = ALU_ADD;
      end
      DECODE: begin
        ctl_d.alusrcb = 2'd3;
        ctl_d.aluop   = ALU_ADD;
      end
      MEMADR: begin
        ctl_d.alusrca = 1'b1;
        ctl_d.alusrcb = 2'd2;
        ctl_d.aluop   = ALU_ADD;
      end
      MEMRD: begin
        ctl_d.iord    = 1'b1;
        ctl_d.memread = 1'b1;
      end
      MEMWB: begin
        ctl_d.regdst   = 2'd0;
        ctl_d.memtoreg = 1'b1;
        ctl_d.regwrite = 1'b1;
      end
      MEMWR: begin
        ctl_d.iord     = 1'b1;
        ctl_d.memwrite = 1'b1;
      end
      RTYPE: begin
        ctl_d.alusrca = 1'b1;
        ctl_d.alusrcb = 2'd0;
        ctl_d.aluop   = ALU_FN;
      end
      RWB: begin
        ctl_d.regdst   = 2'd1;
        ctl_d.regwrite = 1'b1;
      end
      BRANCH: begin
        ctl_d.alusrca      = 1'b1;
        ctl_d.aluop        = ALU_SUB;
        ctl_d.pcwrite_cond = 1'b1;
        ctl_d.pcsource     = 2'd1;
        ctl_d.bne          = bus.opcode == OP_BNE;
      end
      JUMP: begin
        ctl_d.pcwrite  = 1'b1;
        ctl_d.pcsource = 2'd2;
      end
      JAL: begin
        ctl_d.pcwrite  = 1'b1;
        ctl_d.pcsource = 2'd2;
        ctl_d.regdst   = 2'd2;
        ctl_d.regwrite = 1'b1;
      end
      JR: begin
        ctl_d.alusrca  = 1'b1;
        ctl_d.pcwrite  = 1'b1;
        ctl_d.pcsource = 2'd3;
      end
      ADDI: begin
        ctl_d.alusrca = 1'b1;
        ctl_d.alusrcb = 2'd2;
        ctl_d.aluop   = ALU_ADD;
      end
      IWB: begin
        ctl_d.regdst   = 2'd0;
        ctl_d.regwrite = 1'b1;
      end
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= FETCH;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
      ctl_q     <= '0;
    end else begin
      state_q   <= tgt;
      run_q     <= 1'b1;
      illegal_q <= run_q & bad_op;
      ctl_q     <= ctl_d;
    end
  end

  // IR load and PC+4 follow the memory handshake inside FETCH.
  assign bus.irwrite      = ctl_q.fetch & bus.mem_ready;
  assign bus.pcwrite      = ctl_q.pcwrite
                          | (ctl_q.fetch & bus.mem_ready);
  assign bus.pcwrite_cond = ctl_q.pcwrite_cond;
  assign bus.bne          = ctl_q.bne;
  assign bus.iord         = ctl_q.iord;
  assign bus.memread      = ctl_q.memread;
  assign bus.memwrite     = ctl_q.memwrite;
  assign bus.memtoreg     = ctl_q.memtoreg;
  assign bus.regdst       = ctl_q.regdst;
  assign bus.regwrite     = ctl_q.regwrite;
  assign bus.alusrca      = ctl_q.alusrca;
  assign bus.alusrcb      = ctl_q.alusrcb;
  assign bus.aluop        = ctl_q.aluop;
  assign bus.pcsource     = ctl_q.pcsource;
  assign bus.illegal_op   = illegal_q;
  assign bus.state        = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction
// class through its state sequence and checks the strobes.
module tb_multicycle_ctrl;

  logic clock = 1'b0;
  logic Reset;
  int   errs   = 0;
  int   checks = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [4:0] wr;
  assign wr = {bus.regwrite, bus.memwrite,
               bus.pcwrite, bus.irwrite,
               bus.pcwrite_cond};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic nxt(input string tag,
                     input logic [3:0] s);
    @(negedge clock);
    check(tag, 32'(bus.state), 32'(s));
  endtask

  initial begin
    Reset         = 1'b0;
    bus.opcode    = 6'b000000;
    bus.funct     = 6'b100000;
    bus.mem_ready = 1'b0;
    #1 Reset = 1'b1;

    // reset phase
    repeat (3) begin
      @(negedge clock);
      check("rst_state", 32'(bus.state), 0);
      check("rst_wr", 32'(wr), 0);
      check("rst_memrd", 32'(bus.memread), 0);
    end
    bus.mem_ready = 1'b1;
    #1 check("rst_rdy_wr", 32'(wr), 0);
    #1 Reset = 1'b0;
    #1 check("post_rst_wr", 32'(wr), 0);
    check("post_rst_st", 32'(bus.state), 0);

    nxt("t1_fetch", 4'd0);
    check("t1_irwrite", 32'(bus.irwrite), 1);
    check("t1_pcwrite", 32'(bus.pcwrite), 1);
    check("t1_memread", 32'(bus.memread), 1);
    check("t1_iord", 32'(bus.iord), 0);
    check("t1_srcb", 32'(bus.alusrcb), 1);
    nxt("t1_decode", 4'd1);
    check("t1_dec_srcb", 32'(bus.alusrcb), 3);
    check("t1_dec_wr", 32'(wr), 0);

    // add
    nxt("t2_rtype", 4'd6);
    check("t2_aluop", 32'(bus.aluop), 2);
    check("t2_srca", 32'(bus.alusrca), 1);
    check("t2_rw0", 32'(bus.regwrite), 0);
    nxt("t2_rwb", 4'd7);
    check("t2_rw", 32'(bus.regwrite), 1);
    check("t2_rdst", 32'(bus.regdst), 1);
    check("t2_m2r", 32'(bus.memtoreg), 0);
    nxt("t2_fetch", 4'd0);

    // lw with two wait cycles
    bus.opcode = 6'b100011;
    nxt("t3_dec", 4'd1);
    nxt("t3_adr", 4'd2);
    check("t3_srcb", 32'(bus.alusrcb), 2);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt("t3_memrd", 4'd3);
      check("t3_memread", 32'(bus.memread), 1);
      check("t3_iord", 32'(bus.iord), 1);
      check("t3_wr", 32'(wr), 0);
      if (i == 2) bus.mem_ready = 1'b1;
    end
    nxt("t3_memwb", 4'd4);
    check("t3_rw", 32'(bus.regwrite), 1);
    check("t3_m2r", 32'(bus.memtoreg), 1);
    check("t3_rdst", 32'(bus.regdst), 0);
    nxt("t3_fetch", 4'd0);

    // bne then beq
    bus.opcode = 6'b000101;
    nxt("t4_dec", 4'd1);
    nxt("t4_br", 4'd8);
    check("t4_bne", 32'(bus.bne), 1);
    check("t4_pcc", 32'(bus.pcwrite_cond), 1);
    check("t4_aluop", 32'(bus.aluop), 1);
    check("t4_pcsrc", 32'(bus.pcsource), 1);
    nxt("t4_fetch", 4'd0);
    bus.opcode = 6'b000100;
    nxt("t4b_dec", 4'd1);
    nxt("t4b_br", 4'd8);
    check("t4b_bne", 32'(bus.bne), 0);
    nxt("t4b_fetch", 4'd0);

    // jal then jr
    bus.opcode = 6'b000011;
    nxt("t5_dec", 4'd1);
    nxt("t5_jal", 4'd10);
    check("t5_rdst", 32'(bus.regdst), 2);
    check("t5_rw", 32'(bus.regwrite), 1);
    check("t5_pcsrc", 32'(bus.pcsource), 2);
    check("t5_pcw", 32'(bus.pcwrite), 1);
    check("t5_m2r", 32'(bus.memtoreg), 0);
    nxt("t5_fetch", 4'd0);
    bus.opcode = 6'b000000;
    bus.funct  = 6'b001000;
    nxt("t5b_dec", 4'd1);
    nxt("t5b_jr", 4'd11);
    check("t5b_pcsrc", 32'(bus.pcsource), 3);
    check("t5b_pcw", 32'(bus.pcwrite), 1);
    check("t5b_rw", 32'(bus.regwrite), 0);
    nxt("t5b_fetch", 4'd0);

    // addi
    bus.opcode = 6'b001000;
    nxt("ai_dec", 4'd1);
    nxt("ai_addi", 4'd12);
    check("ai_srcb", 32'(bus.alusrcb), 2);
    check("ai_aluop", 32'(bus.aluop), 0);
    nxt("ai_iwb", 4'd13);
    check("ai_rw", 32'(bus.regwrite), 1);
    check("ai_rdst", 32'(bus.regdst), 0);
    nxt("ai_fetch", 4'd0);

    // illegal opcode
    bus.opcode = 6'b111111;
    nxt("t6_dec", 4'd1);
    check("t6_ill0", 32'(bus.illegal_op), 0);
    nxt("t6_fetch", 4'd0);
    check("t6_ill1", 32'(bus.illegal_op), 1);
    check("t6_rw", 32'(bus.regwrite), 0);
    check("t6_mw", 32'(bus.memwrite), 0);
    bus.opcode = 6'b101011;
    nxt("t6_sw_dec", 4'd1);
    check("t6_ill_end", 32'(bus.illegal_op), 0);
    nxt("t6_sw_adr", 4'd2);
    bus.mem_ready = 1'b0;
    nxt("t6_memwr", 4'd5);
    check("t6_mw1", 32'(bus.memwrite), 1);
    check("t6_iord", 32'(bus.iord), 1);
    nxt("t6_memwr_w", 4'd5);
    check("t6_mw_hold", 32'(bus.memwrite), 1);

    // reset mid-store
    #2 Reset = 1'b1;
    #1 check("t6_rst_mw", 32'(bus.memwrite), 0);
    check("t6_rst_st", 32'(bus.state), 0);
    bus.mem_ready = 1'b1;
    @(negedge clock);
    check("t6_rst_wr", 32'(wr), 0);
    Reset = 1'b0;
    nxt("t6_refetch", 4'd0);
    check("t6_re_ir", 32'(bus.irwrite), 1);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
